// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encoding, FSM states
// and the byte-mask helper used for store enables.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    RESP
  } lsu_state_e;

  // Right-justified byte mask for an access of the given size.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 4'b0001;
      SZ_HALF: return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: merges the two read beats, shifts the addressed bytes
// down to bit 0 and zero- or sign-extends according to the access size.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] beat0,
  input  logic [31:0] beat1,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [63:0] merged;

  // Shift the 64-bit beat pair by the byte offset, then extend per size.
  always_comb begin
    merged = {beat1, beat0} >> {off, 3'b000};
    case (size)
      SZ_BYTE: data = {{24{~is_unsigned & merged[7]}}, merged[7:0]};
      SZ_HALF: data = {{16{~is_unsigned & merged[15]}}, merged[15:0]};
      default: data = merged[31:0];
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one request per handshake from execute, issues one or
// two aligned word transactions with byte enables and returns extended data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e state_q, state_d;

  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] beat0_q;
  logic [DATA_W-1:0] rdata_q;

  logic [1:0]        off;
  logic              split;
  logic [3:0]        mask;
  logic [7:0]        be_pair;
  logic [DATA_W-1:0] wdata_beat0;
  logic [DATA_W-1:0] wdata_beat1;
  logic [ADDR_W-3:0] word_idx;
  logic [ADDR_W-3:0] word_idx_next;
  logic [DATA_W-1:0] align_beat0;
  logic [DATA_W-1:0] align_beat1;
  logic [DATA_W-1:0] load_data;
  logic              last_ack;

  // Split decode, store lane placement and address generation.
  always_comb begin
    off           = addr_q[1:0];
    split         = ((size_q == SZ_WORD) && (off != 2'd0)) ||
                    ((size_q == SZ_HALF) && (off == 2'd3));
    mask          = size_mask(size_q);
    be_pair       = {4'b0000, mask} << off;
    wdata_beat0   = wdata_q << {off, 3'b000};
    // Bytes that spilled past lane 3 land in the low lanes of the next word.
    wdata_beat1   = wdata_q >> {3'd4 - {1'b0, off}, 3'b000};
    word_idx      = addr_q[ADDR_W-1:2];
    word_idx_next = word_idx + {{(ADDR_W-3){1'b0}}, 1'b1};
    // Unsplit loads have every addressed byte in the single beat.
    align_beat0   = split ? beat0_q : mem_rdata;
    align_beat1   = split ? mem_rdata : '0;
    last_ack      = mem_ack && (((state_q == ACC0) && !split) || (state_q == ACC1));
  end

  lsu_load_align u_load_align (
    .beat0       (align_beat0),
    .beat1       (align_beat1),
    .off         (off),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (load_data)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_valid) state_d = ACC0;
      ACC0: if (mem_ack) state_d = split ? ACC1 : RESP;
      ACC1: if (mem_ack) state_d = RESP;
      RESP: if (resp_ready) state_d = IDLE;
    endcase
  end

  // Output decode; everything idles at zero outside its active state.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = 4'b0000;
    mem_wdata  = '0;
    unique case (state_q)
      IDLE: req_ready = 1'b1;
      ACC0: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = {word_idx, 2'b00};
        mem_be    = we_q ? be_pair[3:0] : 4'b1111;
        mem_wdata = we_q ? wdata_beat0 : '0;
      end
      ACC1: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = {word_idx_next, 2'b00};
        mem_be    = we_q ? be_pair[7:4] : 4'b1111;
        mem_wdata = we_q ? wdata_beat1 : '0;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
      end
    endcase
  end

  // Request capture, first-beat buffer and response data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      beat0_q <= '0;
      rdata_q <= '0;
    end else begin
      if ((state_q == IDLE) && req_valid) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        // Reserved size code behaves as a word access.
        size_q  <= (req_size == 2'd3) ? SZ_WORD : req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if ((state_q == ACC0) && mem_ack && split && !we_q) begin
        beat0_q <= mem_rdata;
      end
      if (last_ack) begin
        rdata_q <= we_q ? '0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand-written
// split/stall/reset sequences and a randomized run against a byte-array model.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  load_store_unit #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Bench memory (64 bytes, word addressed) and the independent byte model.
  logic [31:0] bmem    [16];
  logic [7:0]  ref_mem [64];

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;
  txn_t log_q[$];

  int          mem_wait  = 0;
  int          wait_cnt  = 0;
  int          stall_cnt = 0;
  bit          rand_wait = 0;
  bit          pend      = 0;
  logic        snap_we;
  logic [31:0] snap_addr;
  logic [3:0]  snap_be;
  logic [31:0] snap_wdata;

  // Memory responder: decides ack on the falling edge, checks held outputs.
  always @(negedge clk) begin
    if (reset) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
      pend     = 0;
    end else begin
      if (pend) begin
        check("mem_hold_req", {31'b0, mem_req}, 32'd1);
        check("mem_hold_addr", mem_addr, snap_addr);
        check("mem_hold_be", {28'b0, mem_be}, {28'b0, snap_be});
        check("mem_hold_we", {31'b0, mem_we}, {31'b0, snap_we});
        check("mem_hold_wdata", mem_wdata, snap_wdata);
        pend = 0;
      end
      if (mem_req) begin
        if (wait_cnt >= mem_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = bmem[mem_addr[5:2]];
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack = 1'b0;
      end
    end
  end

  // Memory responder: completes transactions on the rising edge.
  always @(posedge clk) begin
    if (!reset && mem_req) begin
      if (mem_ack) begin
        log_q.push_back('{we: mem_we, addr: mem_addr, be: mem_be, wdata: mem_wdata});
        if (mem_we) begin
          for (int i = 0; i < 4; i++) begin
            if (mem_be[i]) bmem[mem_addr[5:2]][8*i +: 8] = mem_wdata[8*i +: 8];
          end
        end
        wait_cnt = 0;
        if (rand_wait) mem_wait = $urandom_range(0, 2);
      end else begin
        stall_cnt++;
        pend       = 1;
        snap_we    = mem_we;
        snap_addr  = mem_addr;
        snap_be    = mem_be;
        snap_wdata = mem_wdata;
      end
    end
  end

  // Reference model: little-endian byte memory, addresses wrap at 64 bytes.
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int byte_idx(input logic [31:0] a, input int i);
    logic [31:0] s;
    s = a + 32'(i);
    return int'(s[5:0]);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a);
    logic [31:0] v;
    int          n;
    v = '0;
    n = nbytes(sz);
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[byte_idx(a, i)];
    if (n == 1 && !uns && v[7])  v[31:8]  = '1;
    if (n == 2 && !uns && v[15]) v[31:16] = '1;
    return v;
  endfunction

  function automatic void model_store(input logic [1:0] sz, input logic [31:0] a,
                                      input logic [31:0] wd);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[byte_idx(a, i)] = wd[8*i +: 8];
  endfunction

  // Number of distinct memory words covered by the access.
  function automatic int words_touched(input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] last;
    last = a + 32'(nbytes(sz) - 1);
    return (last[31:2] != a[31:2]) ? 2 : 1;
  endfunction

  // One full request/response exchange; lat counts cycles from accept to resp_valid.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output int lat, output int beats);
    bit          busy_ok;
    bit          hold_ok;
    logic [31:0] first;
    busy_ok = 1;
    hold_ok = 1;
    @(negedge clk);
    log_q.delete();
    stall_cnt    = 0;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      req_valid = 1'b0;
      if (req_ready) busy_ok = 0;
    end while (!resp_valid && lat < 200);
    check("resp_arrives", {31'b0, resp_valid}, 32'd1);
    first = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!resp_valid || resp_rdata !== first || req_ready) hold_ok = 0;
    end
    if (hold > 0) check("resp_hold", {31'b0, hold_ok}, 32'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("busy_not_ready", {31'b0, busy_ok}, 32'd1);
    check("resp_consumed", {31'b0, resp_valid}, 32'd0);
    rd    = first;
    beats = log_q.size();
  endtask

  typedef struct packed {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic [1:0]  beats;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic [31:0] rd;
    int          lat;
    int          beats;
    int          cyc;
    bit          quiet;
    logic        r_we;
    logic [1:0]  r_sz;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    logic [31:0] r_exp;
    int          r_beats;
    logic [31:0] w;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h00000000, 2'd1};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 2'd1};
    vecs[2]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, 32'h00000000, 2'd1};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'hFFFFFF80, 2'd1};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h00000080, 2'd1};
    vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'hFFFF80FF, 2'd1};
    vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h10, 32'h0,        32'h00007F01, 2'd1};
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 32'h04, 32'h44332211, 32'h00000000, 2'd1};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h08, 32'h88776655, 32'h00000000, 2'd1};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h05, 32'h0,        32'h55443322, 2'd2};
    vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h80FF7F01, 2'd1};
    vecs[11] = '{1'b0, 2'd1, 1'b0, 32'h07, 32'h0,        32'h00005544, 2'd2};
    vecs[12] = '{1'b0, 2'd0, 1'b0, 32'h05, 32'h0,        32'h00000022, 2'd1};
    vecs[13] = '{1'b1, 2'd0, 1'b0, 32'h11, 32'h123456A5, 32'h00000000, 2'd1};
    vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h80FFA501, 2'd1};

    reset        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    resp_ready   = 1'b0;
    mem_ack      = 1'b0;
    mem_rdata    = '0;
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      bmem[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end

    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be", {28'b0, mem_be}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Directed vectors, zero-wait memory.
    for (int i = 0; i < 15; i++) begin
      do_req(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata, 0,
             rd, lat, beats);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      check($sformatf("vec%0d_beats", i), 32'(beats), {30'b0, vecs[i].beats});
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(1 + int'(vecs[i].beats)));
      if (vecs[i].we) model_store(vecs[i].sz, vecs[i].addr, vecs[i].wdata);
      if (i == 0 && beats == 1) begin
        check("sw_txn_we", {31'b0, log_q[0].we}, 32'd1);
        check("sw_txn_addr", log_q[0].addr, 32'h10);
        check("sw_txn_be", {28'b0, log_q[0].be}, 32'hF);
        check("sw_txn_wdata", log_q[0].wdata, 32'hDEADBEEF);
      end
      if (i == 9 && beats == 2) begin
        check("lw_split_addr0", log_q[0].addr, 32'h04);
        check("lw_split_addr1", log_q[1].addr, 32'h08);
        check("lw_split_be0", {28'b0, log_q[0].be}, 32'hF);
        check("lw_split_be1", {28'b0, log_q[1].be}, 32'hF);
      end
    end

    // Split halfword store across a word boundary.
    do_req(1'b1, 2'd1, 1'b0, 32'h07, 32'h0000BEEF, 0, rd, lat, beats);
    model_store(2'd1, 32'h07, 32'h0000BEEF);
    check("sh_split_beats", 32'(beats), 32'd2);
    check("sh_split_rdata", rd, 32'd0);
    if (beats == 2) begin
      check("sh_txn0_addr", log_q[0].addr, 32'h04);
      check("sh_txn0_be", {28'b0, log_q[0].be}, 32'h8);
      check("sh_txn0_wdata", log_q[0].wdata, 32'hEF000000);
      check("sh_txn1_addr", log_q[1].addr, 32'h08);
      check("sh_txn1_be", {28'b0, log_q[1].be}, 32'h1);
      check("sh_txn1_wdata", log_q[1].wdata, 32'h000000BE);
    end
    do_req(1'b0, 2'd1, 1'b1, 32'h07, 32'h0, 0, rd, lat, beats);
    check("sh_split_readback", rd, 32'h0000BEEF);

    // Word load wrapping past the top of the address space.
    do_req(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 0, rd, lat, beats);
    check("wrap_rdata", rd, model_load(2'd2, 1'b0, 32'hFFFFFFFE));
    check("wrap_beats", 32'(beats), 32'd2);
    if (beats == 2) check("wrap_addr1", log_q[1].addr, 32'h00000000);

    // Memory stalls three cycles per beat, consumer stalls two cycles.
    mem_wait = 3;
    do_req(1'b0, 2'd2, 1'b0, 32'h05, 32'h0, 2, rd, lat, beats);
    check("stall_rdata", rd, model_load(2'd2, 1'b0, 32'h05));
    check("stall_latency", 32'(lat), 32'd9);
    check("stall_cycles", 32'(stall_cnt), 32'd6);

    // Randomized traffic against the model.
    rand_wait = 1;
    mem_wait  = 0;
    for (int k = 0; k < 300; k++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_sz   = 2'($urandom_range(0, 3));
      r_uns  = 1'($urandom_range(0, 1));
      r_addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) r_addr = r_addr | 32'hFFFFFFC0;
      r_wd    = $urandom;
      r_exp   = r_we ? 32'd0 : model_load(r_sz, r_uns, r_addr);
      r_beats = words_touched(r_sz, r_addr);
      do_req(r_we, r_sz, r_uns, r_addr, r_wd, int'($urandom_range(0, 2)), rd, lat, beats);
      if (r_we) model_store(r_sz, r_addr, r_wd);
      check($sformatf("rand%0d_rdata", k), rd, r_exp);
      check($sformatf("rand%0d_beats", k), 32'(beats), 32'(r_beats));
      check($sformatf("rand%0d_latency", k), 32'(lat), 32'(1 + r_beats + stall_cnt));
    end
    rand_wait = 0;

    // Reset during the second beat of a split load.
    mem_wait = 3;
    @(negedge clk);
    log_q.delete();
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    req_addr     = 32'h05;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (log_q.size() < 1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_acc1_req", {31'b0, mem_req}, 32'd1);
    check("rst_acc1_addr", mem_addr, 32'h08);
    #1;
    reset    = 1'b1;
    pend     = 0;
    wait_cnt = 0;
    mem_wait = 0;
    #1;
    check("rst_async_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_async_mem_addr", mem_addr, 32'd0);
    check("rst_async_mem_be", {28'b0, mem_be}, 32'd0);
    check("rst_async_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_async_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    quiet = 1;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || mem_req) quiet = 0;
    end
    check("rst_no_response", {31'b0, quiet}, 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, lat, beats);
    check("post_rst_rdata", rd, model_load(2'd2, 1'b0, 32'h10));
    check("post_rst_latency", 32'(lat), 32'd2);

    // Final memory image must match the model.
    for (int i = 0; i < 16; i++) begin
      check($sformatf("mem_word%0d", i), bmem[i],
            {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
